multicore_pc_sequencer: RTL and testbench
=========================================

// Module: multicore_pc_sequencer
// PURPOSE
//  N-core program sequencer. Each core has a program counter, a call/return stack, and opcode
//  decode of its 16-bit instruction word. All cores share one 1-bit data memory with a
//  round-robin write arbiter. Sits between the shared instruction RAM (pc_out -> instr_in)
//  and the per-core accumulator datapaths.
//  Successor to the fixed 4-core wrapper, adding:
//  - any core count and per-core start address;
//  - conflict-free stores: losers stall, they are not silently merged;
//  - stack overflow and underflow detection.
// PARAMETERS
//  NUM_CORES     4   number of cores (1..16)
//  PC_W          16  program-counter width
//  START_STRIDE  3   reset PC of core i = i*START_STRIDE
//  STACK_DEPTH   4   return-stack entries per core (>=1)
//  DATA_AW       6   shared data-memory address width (2**DATA_AW bits)
// PORTS
//  clk        in   1              rising-edge clock
//  reset      in   1              asynchronous, active-low
//  run        in   1              global advance enable; 0 freezes all PCs, stacks and memory
//  instr_in   in   NUM_CORES*16   instruction word per core, slice [16*i+:16]
//  cond       in   NUM_CORES      jump condition per core
//  acc_bit    in   NUM_CORES      accumulator bit per core, written by STORE
//  pc_out     out  NUM_CORES*PC_W registered PC per core
//  data_out   out  NUM_CORES      combinational read of mem[instr_in[i][DATA_AW-1:0]]
//  stall      out  NUM_CORES      combinational; 1 = core i lost store arbitration this cycle
//  err        out  NUM_CORES      sticky; stack overflow or underflow
// BEHAVIOUR
//  Opcode = instr[15:14]; target = {0, instr[13:0]} zero-extended to PC_W.
//  - 00 STEP:   PC <= PC+1.
//  - 10 STORE:  request write of acc_bit[i] to mem[instr[DATA_AW-1:0]].
//               Granted: PC <= PC+1. Not granted: stall=1, PC holds.
//  - 01 JUMP:   cond=1: push PC+1, then PC <= target. cond=0: PC <= PC+1.
//  - 11 RETURN: pop; PC <= popped value.
//  Reset (async, active-low):
//  - pc_out[i] = i*START_STRIDE; stacks empty; err = 0; arbiter pointer = 0.
//  - mem cleared to 0.
//  Per-core registered update, one cycle latency. Updates only when run=1 and err[i]=0.
//  An errored core holds its PC until reset.
//  PC arithmetic is modulo 2**PC_W: 0xFFFF+1 wraps to 0.
//  Arbitration:
//  - One memory write per cycle.
//  - Grant goes to the first requesting core at or after ptr, in increasing index order, with wrap.
//  - After a grant, ptr <= granted+1 mod NUM_CORES. ptr holds when there are no requests.
//  - Arbitration applies even when two requests target different addresses.
//  - stall is 0 whenever run=0 or err[i]=1.
//  Read/write ordering: data_out shows pre-write contents. A write is visible the next cycle.
//  Stack:
//  - Push when full: err[i] <= 1, no push, PC holds.
//  - Pop when empty: err[i] <= 1, PC holds.
//  err never clears except on reset.
//  reset asserted mid-cycle forces all state to reset values immediately. No partial store completes.
// STRUCTURE
//  Shared package multicore_seq_pkg:
//  - OP_STEP=2'b00, OP_JUMP=2'b01, OP_STORE=2'b10, OP_RET=2'b11;
//  - instruction field positions (OPC_HI=15, OPC_LO=14, TGT_W=14).
//  Sub-module pc_stack_core, generated NUM_CORES times. It holds PC, return stack, err and decode.
//  Inputs: grant, run. Outputs: store request, PC.
//  The top holds the arbiter, the data memory and the packed-vector slicing.
// TESTING
//  1. Reset release, run=1, all STEP -> pc_out = 1,4,7,10 after one clk; err=0.
//  2. Cores 0 and 2 STORE same cycle, ptr=0 -> core0 granted, stall[2]=1, PC2 holds.
//     Next cycle core2 granted; ptr=3.
//  3. Core1 JUMP target 0x0020, cond=1 -> PC1=0x0020, stack depth 1.
//     Then RETURN -> PC1 = old PC+1.
//  4. Five taken JUMPs on core3 (STACK_DEPTH=4) -> err[3]=1 on the 5th; PC3 frozen.
//     Other cores unaffected.
//  5. RETURN on empty stack -> err=1. Assert reset mid-run -> err=0, PCs return to start values.
//  6. STORE acc_bit=1 to addr 5, with data_out read of addr 5 in the same cycle -> reads 0,
//     then reads 1 next cycle. run=0 -> all PCs and memory unchanged.

Source files
------------

// File: rtl/multicore_pc_sequencer_pkg.sv
// Shared opcode encoding and instruction field positions for the multicore PC sequencer.
// Latency: n/a (types and constants only); backpressure: n/a.
package multicore_seq_pkg;

    typedef enum logic [1:0] {
        OP_STEP  = 2'b00,
        OP_JUMP  = 2'b01,
        OP_STORE = 2'b10,
        OP_RET   = 2'b11
    } opcode_e;

    localparam int INSTR_W = 16;
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 14;
    localparam int TGT_W   = 14;

    function automatic opcode_e get_op(input logic [INSTR_W-1:0] instr);
        return opcode_e'(instr[OPC_HI:OPC_LO]);
    endfunction

endpackage

// File: rtl/multicore_pc_sequencer_if.sv
// Per-core instruction/status bundle between the instruction RAM, the datapaths and the sequencer.
// Latency: n/a (wiring only); backpressure: stall lines flag cores that lost store arbitration.
interface multicore_pc_sequencer_if #(
    parameter int NUM_CORES = 4,
    parameter int PC_W      = 16
);
    logic                      run;
    logic [NUM_CORES*16-1:0]   instr_in;
    logic [NUM_CORES-1:0]      cond;
    logic [NUM_CORES-1:0]      acc_bit;
    logic [NUM_CORES*PC_W-1:0] pc_out;
    logic [NUM_CORES-1:0]      data_out;
    logic [NUM_CORES-1:0]      stall;
    logic [NUM_CORES-1:0]      err;

    modport master (
        output run, instr_in, cond, acc_bit,
        input  pc_out, data_out, stall, err
    );

    modport slave (
        input  run, instr_in, cond, acc_bit,
        output pc_out, data_out, stall, err
    );
endinterface

// File: rtl/multicore_pc_sequencer_pc_stack_core.sv
// One core: program counter, return stack, sticky error flag and opcode decode.
// Latency: 1 cycle PC update; backpressure: a STORE without grant holds the PC.
module pc_stack_core
    import multicore_seq_pkg::*;
#(
    parameter int IDX          = 0,
    parameter int PC_W         = 16,
    parameter int START_STRIDE = 3,
    parameter int STACK_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic               i_cond,
    input  logic               i_grant,
    output logic               o_store_req,
    output logic [PC_W-1:0]    o_pc,
    output logic               o_err
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PC_W-1:0] START_PC = PC_W'(IDX * START_STRIDE);

    logic [PC_W-1:0] r_pc;
    logic [SPW-1:0]  r_sp;
    logic            r_err;
    logic [PC_W-1:0] r_stack [0:(1<<IW)-1];

    opcode_e         w_op;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_tgt;
    logic            w_full;
    logic            w_empty;
    logic [IW-1:0]   w_push_idx;
    logic [IW-1:0]   w_pop_idx;

    assign w_op        = get_op(i_instr);
    assign w_pc_inc    = r_pc + 1'b1;
    assign w_tgt       = PC_W'(i_instr[TGT_W-1:0]);
    assign w_full      = (r_sp == SPW'(STACK_DEPTH));
    assign w_empty     = (r_sp == '0);
    assign w_push_idx  = IW'(r_sp);
    assign w_pop_idx   = IW'(r_sp - 1'b1);
    assign o_store_req = i_run && !r_err && (w_op == OP_STORE);
    assign o_pc        = r_pc;
    assign o_err       = r_err;

    // Overflow/underflow leave PC and stack untouched; the core freezes until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc  <= START_PC;
            r_sp  <= '0;
            r_err <= 1'b0;
            for (int k = 0; k < (1 << IW); k++) r_stack[k] <= '0;
        end else if (i_run && !r_err) begin
            unique case (w_op)
                OP_STEP:  r_pc <= w_pc_inc;
                OP_STORE: if (i_grant) r_pc <= w_pc_inc;
                OP_JUMP: begin
                    if (!i_cond) begin
                        r_pc <= w_pc_inc;
                    end else if (w_full) begin
                        r_err <= 1'b1;
                    end else begin
                        r_stack[w_push_idx] <= w_pc_inc;
                        r_sp                <= r_sp + 1'b1;
                        r_pc                <= w_tgt;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        r_err <= 1'b1;
                    end else begin
                        r_sp <= r_sp - 1'b1;
                        r_pc <= r_stack[w_pop_idx];
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/multicore_pc_sequencer.sv
// N-core program sequencer: per-core PC/stack cores plus a shared 1-bit data memory with round-robin write arbiter.
// Latency: 1 cycle PC/memory update, combinational read; backpressure: store losers see stall=1 and hold PC.
module multicore_pc_sequencer
    import multicore_seq_pkg::*;
#(
    parameter int NUM_CORES    = 4,
    parameter int PC_W         = 16,
    parameter int START_STRIDE = 3,
    parameter int STACK_DEPTH  = 4,
    parameter int DATA_AW      = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    multicore_pc_sequencer_if.slave  bus
);
    localparam int PW    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int MEM_N = 1 << DATA_AW;

    logic [NUM_CORES-1:0] w_req;
    logic [NUM_CORES-1:0] w_grant;
    logic                 w_any;
    logic [PW-1:0]        w_gnt_idx;
    logic [DATA_AW-1:0]   w_wr_addr;
    logic                 w_wr_bit;
    int                   w_scan_idx;
    logic [PW-1:0]        r_ptr;
    logic [MEM_N-1:0]     r_mem;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        pc_stack_core #(
            .IDX          (g),
            .PC_W         (PC_W),
            .START_STRIDE (START_STRIDE),
            .STACK_DEPTH  (STACK_DEPTH)
        ) u_core (
            .clk          (clk),
            .reset        (reset),
            .i_run        (bus.run),
            .i_instr      (bus.instr_in[INSTR_W*g +: INSTR_W]),
            .i_cond       (bus.cond[g]),
            .i_grant      (w_grant[g]),
            .o_store_req  (w_req[g]),
            .o_pc         (bus.pc_out[PC_W*g +: PC_W]),
            .o_err        (bus.err[g])
        );

        // Read returns pre-write contents; a granted store lands at the clock edge.
        assign bus.data_out[g] = r_mem[bus.instr_in[INSTR_W*g +: DATA_AW]];
        assign bus.stall[g]    = w_req[g] & ~w_grant[g];
    end

    always_comb begin
        w_grant    = '0;
        w_any      = 1'b0;
        w_gnt_idx  = '0;
        w_wr_addr  = '0;
        w_wr_bit   = 1'b0;
        w_scan_idx = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_scan_idx = (int'(r_ptr) + k) % NUM_CORES;
            if (!w_any && w_req[w_scan_idx]) begin
                w_any               = 1'b1;
                w_grant[w_scan_idx] = 1'b1;
                w_gnt_idx           = PW'(w_scan_idx);
                w_wr_addr           = bus.instr_in[INSTR_W*w_scan_idx +: DATA_AW];
                w_wr_bit            = bus.acc_bit[w_scan_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
            r_mem <= '0;
        end else if (w_any) begin
            r_ptr            <= (w_gnt_idx == PW'(NUM_CORES - 1)) ? '0 : w_gnt_idx + 1'b1;
            r_mem[w_wr_addr] <= w_wr_bit;
        end
    end

endmodule

// File: tb/tb_multicore_pc_sequencer.sv
// Randomized scoreboard bench for multicore_pc_sequencer against a queue-based reference model.
// Stimulus pushes expected results per cycle; a separate monitor pops and compares.
module tb_multicore_pc_sequencer;
    localparam int N     = 4;
    localparam int PCW   = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multicore_pc_sequencer_if #(.NUM_CORES(N), .PC_W(PCW)) bus ();

    multicore_pc_sequencer #(
        .NUM_CORES(N), .PC_W(PCW), .START_STRIDE(3), .STACK_DEPTH(DEPTH), .DATA_AW(AW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [N*PCW-1:0] pc;
        logic [N-1:0]     err;
        logic [N-1:0]     dout;
        logic [N-1:0]     stall;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    int unsigned m_pc  [N];
    int unsigned m_stk [N][$];
    logic        m_err [N];
    int          m_ptr;
    logic        m_mem [1<<AW];

    function automatic logic [15:0] mk(input logic [1:0] op, input int unsigned low);
        logic [13:0] l;
        l = 14'(low);
        return {op, l};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pc[i]  = i * 3;
            m_err[i] = 1'b0;
            m_stk[i].delete();
        end
        m_ptr = 0;
        for (int a = 0; a < (1<<AW); a++) m_mem[a] = 1'b0;
    endtask

    function automatic exp_t pack_state();
        exp_t e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            e.pc[PCW*i +: PCW] = 16'(m_pc[i]);
            e.err[i]           = m_err[i];
        end
        return e;
    endfunction

    task automatic cycle(input logic r, input logic [N*16-1:0] ins,
                         input logic [N-1:0] c, input logic [N-1:0] a);
        exp_t        e;
        logic [N-1:0] req;
        logic [N-1:0] dout;
        logic [N-1:0] stl;
        int           g;
        logic [15:0]  w;
        @(negedge clk);
        bus.run      = r;
        bus.instr_in = ins;
        bus.cond     = c;
        bus.acc_bit  = a;
        g = -1;
        for (int i = 0; i < N; i++) begin
            w       = ins[16*i +: 16];
            dout[i] = m_mem[w[AW-1:0]];
            req[i]  = r && !m_err[i] && (w[15:14] == 2'b10);
        end
        for (int k = 0; k < N; k++)
            if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        for (int i = 0; i < N; i++) stl[i] = req[i] && (i != g);
        for (int i = 0; i < N; i++) begin
            w = ins[16*i +: 16];
            if (r && !m_err[i]) begin
                case (w[15:14])
                    2'b00: m_pc[i] = (m_pc[i] + 1) & 32'hFFFF;
                    2'b10: if (i == g) m_pc[i] = (m_pc[i] + 1) & 32'hFFFF;
                    2'b01: begin
                        if (!c[i])                          m_pc[i] = (m_pc[i] + 1) & 32'hFFFF;
                        else if (m_stk[i].size() == DEPTH)  m_err[i] = 1'b1;
                        else begin
                            m_stk[i].push_back((m_pc[i] + 1) & 32'hFFFF);
                            m_pc[i] = int'(w[13:0]);
                        end
                    end
                    default: begin
                        if (m_stk[i].size() == 0) m_err[i] = 1'b1;
                        else                      m_pc[i] = m_stk[i].pop_back();
                    end
                endcase
            end
        end
        if (g >= 0) begin
            w = ins[16*g +: 16];
            m_mem[w[AW-1:0]] = a[g];
            m_ptr = (g + 1) % N;
        end
        e       = pack_state();
        e.dout  = dout;
        e.stall = stl;
        q.push_back(e);
    endtask

    // Reset asserted between edges; outputs are checked while it is still held.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        bus.run      = 1'b0;
        bus.instr_in = '0;
        bus.cond     = '0;
        bus.acc_bit  = '0;
        #2;
        reset = 1'b0;
        model_reset();
        e = pack_state();
        q.push_back(e);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: combinational outputs before the edge, registered state just after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("data_out", 64'(bus.data_out), 64'(e.dout));
                chk("stall",    64'(bus.stall),    64'(e.stall));
                @(posedge clk);
                #1;
                chk("pc_out",   64'(bus.pc_out),   64'(e.pc));
                chk("err",      64'(bus.err),      64'(e.err));
            end
        end
    end

    initial begin
        logic [N*16-1:0] ins;
        logic [1:0]      op;
        int unsigned     rv;
        bus.run      = 1'b0;
        bus.instr_in = '0;
        bus.cond     = '0;
        bus.acc_bit  = '0;
        model_reset();
        do_reset();

        // All STEP after reset release
        cycle(1'b1, {mk(2'b00, 0), mk(2'b00, 0), mk(2'b00, 0), mk(2'b00, 0)}, '0, '0);
        // Cores 0 and 2 contend, then core 2 retries alone
        cycle(1'b1, {mk(2'b00, 0), mk(2'b10, 1), mk(2'b00, 0), mk(2'b10, 1)}, '0, 4'b0101);
        cycle(1'b1, {mk(2'b00, 0), mk(2'b10, 1), mk(2'b00, 0), mk(2'b00, 1)}, '0, 4'b0100);
        // Core 1 call and return
        cycle(1'b1, {mk(2'b00, 0), mk(2'b00, 0), mk(2'b01, 'h20), mk(2'b00, 0)}, 4'b0010, '0);
        cycle(1'b1, {mk(2'b00, 0), mk(2'b00, 0), mk(2'b11, 0), mk(2'b00, 0)}, '0, '0);
        // Core 3 overflows on the fifth taken jump
        for (int k = 0; k < 6; k++)
            cycle(1'b1, {mk(2'b01, 'h100 + k), mk(2'b00, 0), mk(2'b00, 0), mk(2'b00, 0)}, 4'b1000, '0);
        // Core 0 underflows, then reset mid-run
        cycle(1'b1, {mk(2'b00, 0), mk(2'b00, 0), mk(2'b00, 0), mk(2'b11, 0)}, '0, '0);
        cycle(1'b1, {mk(2'b00, 0), mk(2'b00, 0), mk(2'b00, 0), mk(2'b00, 0)}, '0, '0);
        do_reset();
        // Store to addr 5 with same-cycle read, then read-back, then frozen cycles
        cycle(1'b1, {mk(2'b00, 5), mk(2'b00, 5), mk(2'b00, 5), mk(2'b10, 5)}, '0, 4'b0001);
        cycle(1'b1, {mk(2'b00, 5), mk(2'b00, 5), mk(2'b00, 5), mk(2'b00, 5)}, '0, '0);
        cycle(1'b0, {mk(2'b10, 5), mk(2'b01, 9), mk(2'b11, 5), mk(2'b10, 5)}, 4'b1111, '0);
        cycle(1'b0, {mk(2'b00, 5), mk(2'b00, 5), mk(2'b00, 5), mk(2'b00, 5)}, '0, '0);

        for (int n = 0; n < 800; n++) begin
            if (n % 100 == 99) do_reset();
            for (int i = 0; i < N; i++) begin
                rv = $urandom_range(0, 9);
                op = (rv < 4) ? 2'b00 : (rv < 7) ? 2'b10 : (rv < 9) ? 2'b01 : 2'b11;
                if (op == 2'b01) ins[16*i +: 16] = mk(op, $urandom_range(0, 16383));
                else             ins[16*i +: 16] = mk(op, $urandom_range(0, 7));
            end
            cycle(($urandom_range(0, 9) != 0), ins, 4'($urandom), 4'($urandom));
        end

        for (int t = 0; t < 20 && q.size() != 0; t++) @(posedge clk);
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
